// File: rtl/mc_main_ctrl.sv
// ---------------------------------------------------------------------------
// mc_main_ctrl
// Multicycle main control FSM for the MIPS core. It decodes the IR opcode,
// sequences fetch/decode/execute/memory/writeback and drives every datapath
// enable, including the 4-bit ALUOp consumed by the ALU control decoder.
// A watchdog halts the machine with a sticky bus error when a memory access
// never completes.
//
// Parameters:
//   WAIT_MAX  cycles a memory state waits for mem_ready before bus error
//   WAIT_W    width of the wait counter (must hold WAIT_MAX)
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   opcode[5:0]       IR[31:26], valid from DECODE onward
//   mem_ready         memory completes the current access this cycle
//   IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond, BranchNe,
//   PCSrc[1:0], ALUSrcA, ALUSrcB[1:0], ALUOp[3:0], RegDst, MemtoReg,
//   RegWrite          datapath controls
//   bus_err           sticky memory-wait timeout flag
//   illegal_instr     sticky undefined-opcode flag
//
// Optional feature: define MC_MAIN_CTRL_TRAP_EN to trap undefined opcodes
// (FSM parks in TRAP, illegal_instr set). Without it undefined opcodes
// execute as a NOP and illegal_instr is tied low.
// ---------------------------------------------------------------------------
module mc_main_ctrl #(
    parameter int WAIT_MAX = 255,
    parameter int WAIT_W   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       BranchNe,
    output logic [1:0] PCSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUOp,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       bus_err,
    output logic       illegal_instr
);

    typedef enum logic [3:0] {
        RST, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXEC_R, RWB, EXEC_I, IWB, BRANCH, JUMP, HALT, TRAP
    } state_t;

    // Registered control bundle; in_fetch marks FETCH so the mem_ready
    // qualified strobes can be formed without re-decoding the state.
    typedef struct packed {
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       in_fetch;
    } ctrl_t;

    state_t              state;
    state_t              state_nxt;
    ctrl_t               ctrl;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                waiting;
    logic                wd_expire;
    logic                bus_err_q;

    // Control values for a given state. RST, HALT and TRAP fall through to
    // all zeros.
    function automatic ctrl_t decode_ctrl(input state_t s, input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
                c.alu_op    = 4'b0010;
                c.in_fetch  = 1'b1;
            end
            DECODE: begin
                c.alu_src_b = 2'b11;
                c.alu_op    = 4'b0010;
            end
            MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_op    = 4'b0011;
            end
            MEMRD: begin
                c.iord     = 1'b1;
                c.mem_read = 1'b1;
            end
            MEMWB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            MEMWR: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
            end
            EXEC_R: begin
                c.alu_src_a = 1'b1;
            end
            RWB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            EXEC_I: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_op    = op[3:0];
            end
            IWB: begin
                c.reg_write = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = op[3:0];
                c.pc_write_cond = 1'b1;
                c.branch_ne     = op[0];
                c.pc_src        = 2'b01;
            end
            JUMP: begin
                c.pc_write = 1'b1;
                c.pc_src   = 2'b10;
            end
            default: ;
        endcase
        return c;
    endfunction

    // Next-state selection. Memory states hold until mem_ready; the
    // watchdog overrides the hold once the wait count reaches WAIT_MAX, but
    // a mem_ready on that same cycle still wins.
    always_comb begin
        state_nxt = state;
        wd_expire = 1'b0;
        waiting   = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
        case (state)
            RST:    state_nxt = FETCH;
            FETCH:  if (mem_ready) state_nxt = DECODE;
            DECODE: begin
                case (opcode)
                    6'b000000:             state_nxt = EXEC_R;
                    6'b100011, 6'b101011:  state_nxt = MEMADR;
                    6'b000100, 6'b000101:  state_nxt = BRANCH;
                    6'b000010:             state_nxt = JUMP;
                    6'b001000, 6'b001010, 6'b001011,
                    6'b001100, 6'b001101, 6'b001110:
                                           state_nxt = EXEC_I;
`ifdef MC_MAIN_CTRL_TRAP_EN
                    default:               state_nxt = TRAP;
`else
                    default:               state_nxt = FETCH;
`endif
                endcase
            end
            MEMADR: state_nxt = opcode[3] ? MEMWR : MEMRD;
            MEMRD:  if (mem_ready) state_nxt = MEMWB;
            MEMWB:  state_nxt = FETCH;
            MEMWR:  if (mem_ready) state_nxt = FETCH;
            EXEC_R: state_nxt = RWB;
            RWB:    state_nxt = FETCH;
            EXEC_I: state_nxt = IWB;
            IWB:    state_nxt = FETCH;
            BRANCH: state_nxt = FETCH;
            JUMP:   state_nxt = FETCH;
            default: state_nxt = state;
        endcase
        if (waiting && !mem_ready && (wait_cnt == WAIT_W'(WAIT_MAX))) begin
            state_nxt = HALT;
            wd_expire = 1'b1;
        end
    end

    // State, registered controls, watchdog counter and sticky flags. The
    // counter only advances while a memory state is stalled, so any state
    // change or a mem_ready returns it to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RST;
            ctrl      <= '0;
            wait_cnt  <= '0;
            bus_err_q <= 1'b0;
`ifdef MC_MAIN_CTRL_TRAP_EN
            illegal_instr <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            ctrl  <= decode_ctrl(state_nxt, opcode);
            if (waiting && !mem_ready && (state_nxt == state))
                wait_cnt <= wait_cnt + WAIT_W'(1);
            else
                wait_cnt <= '0;
            if (wd_expire)
                bus_err_q <= 1'b1;
`ifdef MC_MAIN_CTRL_TRAP_EN
            if ((state == DECODE) && (state_nxt == TRAP))
                illegal_instr <= 1'b1;
`endif
        end
    end

`ifndef MC_MAIN_CTRL_TRAP_EN
    assign illegal_instr = 1'b0;
`endif

    // IR and PC load in FETCH only when the instruction word actually arrives.
    assign IRWrite     = ctrl.in_fetch & mem_ready;
    assign PCWrite     = ctrl.pc_write | (ctrl.in_fetch & mem_ready);
    assign IorD        = ctrl.iord;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign BranchNe    = ctrl.branch_ne;
    assign PCSrc       = ctrl.pc_src;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;
    assign RegDst      = ctrl.reg_dst;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign RegWrite    = ctrl.reg_write;
    assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mc_main_ctrl
// Bench for mc_main_ctrl with WAIT_MAX=4. A microprogram model (a queue of
// instruction steps per opcode class) predicts the full control vector every
// cycle; directed instruction runs add literal cycle counts and field values.
// ---------------------------------------------------------------------------
module tb_mc_main_ctrl;

    localparam int WAIT_MAX = 4;
    localparam int WAIT_W   = 3;

    localparam int S_IDLE  = 0;
    localparam int S_IF    = 1;
    localparam int S_ID    = 2;
    localparam int S_ADDR  = 3;
    localparam int S_LOAD  = 4;
    localparam int S_LWB   = 5;
    localparam int S_STORE = 6;
    localparam int S_EXR   = 7;
    localparam int S_RWB   = 8;
    localparam int S_EXI   = 9;
    localparam int S_IWB   = 10;
    localparam int S_BR    = 11;
    localparam int S_J     = 12;
    localparam int S_DEAD  = 13;

    logic       clock;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond, BranchNe;
    logic [1:0] PCSrc, ALUSrcB;
    logic       ALUSrcA, RegDst, MemtoReg, RegWrite, bus_err, illegal_instr;
    logic [3:0] ALUOp;
    logic [20:0] dutVec;

    int checks = 0;
    int errors = 0;
    int fetchDelay = 0;
    int memDelay = 0;

    int prog[$];
    int cur = S_IDLE;
    int mwait = 0;
    logic mbus = 1'b0;
    logic mill = 1'b0;
    bit stepDone;

    mc_main_ctrl #(.WAIT_MAX(WAIT_MAX), .WAIT_W(WAIT_W)) dut (
        .clk(clock), .rst(reset), .opcode(opcode), .mem_ready(mem_ready),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNe(BranchNe),
        .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .bus_err(bus_err), .illegal_instr(illegal_instr)
    );

    assign dutVec = {IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond, BranchNe,
                     PCSrc, ALUSrcA, ALUSrcB, ALUOp, RegDst, MemtoReg, RegWrite,
                     bus_err, illegal_instr};

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Expected control vector for a microprogram step, straight from the
    // per-step control table.
    function automatic logic [20:0] expVec(input int st, input logic [5:0] op,
                                           input logic rdy, input logic be, input logic il);
        logic iord, mr, mw, irw, pcw, pcc, bne, asa, rd, m2r, rw;
        logic [1:0] pcs, asb;
        logic [3:0] aop;
        {iord, mr, mw, irw, pcw, pcc, bne, asa, rd, m2r, rw} = '0;
        pcs = 2'b00; asb = 2'b00; aop = 4'b0000;
        case (st)
            S_IF:    begin mr = 1; irw = rdy; pcw = rdy; asb = 2'b01; aop = 4'b0010; end
            S_ID:    begin asb = 2'b11; aop = 4'b0010; end
            S_ADDR:  begin asa = 1; asb = 2'b10; aop = 4'b0011; end
            S_LOAD:  begin iord = 1; mr = 1; end
            S_LWB:   begin m2r = 1; rw = 1; end
            S_STORE: begin iord = 1; mw = 1; end
            S_EXR:   begin asa = 1; end
            S_RWB:   begin rd = 1; rw = 1; end
            S_EXI:   begin asa = 1; asb = 2'b10; aop = op[3:0]; end
            S_IWB:   begin rw = 1; end
            S_BR:    begin asa = 1; aop = op[3:0]; pcc = 1; bne = op[0]; pcs = 2'b01; end
            S_J:     begin pcw = 1; pcs = 2'b10; end
            default: ;
        endcase
        return {iord, mr, mw, irw, pcw, pcc, bne, pcs, asa, asb, aop, rd, m2r, rw, be, il};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Microprogram model: each instruction is fetch+decode followed by the
    // step list of its opcode class; memory steps repeat until mem_ready or
    // until the wait budget is spent.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            prog.delete();
            cur = S_IDLE; mwait = 0; mbus = 1'b0; mill = 1'b0;
        end else begin
            stepDone = 1'b0;
            if (cur == S_DEAD) begin
                stepDone = 1'b0;
            end else if (cur == S_IF || cur == S_LOAD || cur == S_STORE) begin
                if (mem_ready) stepDone = 1'b1;
                else if (mwait == WAIT_MAX) begin
                    prog.delete(); prog.push_back(S_DEAD);
                    cur = S_DEAD; mwait = 0; mbus = 1'b1;
                end else mwait++;
            end else begin
                stepDone = 1'b1;
            end
            if (stepDone) begin
                if (cur == S_ID) begin
                    case (opcode)
                        6'b000000: begin prog.push_back(S_EXR); prog.push_back(S_RWB); end
                        6'b100011: begin prog.push_back(S_ADDR); prog.push_back(S_LOAD); prog.push_back(S_LWB); end
                        6'b101011: begin prog.push_back(S_ADDR); prog.push_back(S_STORE); end
                        6'b000100, 6'b000101: prog.push_back(S_BR);
                        6'b000010: prog.push_back(S_J);
                        6'b001000, 6'b001010, 6'b001011, 6'b001100, 6'b001101, 6'b001110:
                            begin prog.push_back(S_EXI); prog.push_back(S_IWB); end
                        default: begin
`ifdef MC_MAIN_CTRL_TRAP_EN
                            prog.push_back(S_DEAD); mill = 1'b1;
`endif
                        end
                    endcase
                end
                if (prog.size() > 0) void'(prog.pop_front());
                if (prog.size() == 0) begin prog.push_back(S_IF); prog.push_back(S_ID); end
                cur = prog[0];
                mwait = 0;
            end
        end
    end

    // Every-cycle comparison against the model, mid-cycle.
    always @(negedge clock) begin
        checkOutput("ctrl vector", {11'b0, dutVec}, {11'b0, expVec(cur, opcode, mem_ready, mbus, mill)});
    end

    // mem_ready driver: each memory step answers after its programmed delay.
    initial begin
        mem_ready = 1'b0;
        forever begin
            @(posedge clock);
            #2;
            if (cur == S_IF) mem_ready = (mwait >= fetchDelay);
            else if (cur == S_LOAD || cur == S_STORE) mem_ready = (mwait >= memDelay);
            else mem_ready = 1'b0;
        end
    end

    logic [3:0] snapAlu;
    logic       snapNe, snapCond, snapRegDst, snapRegWrite;
    logic [1:0] snapSrcB;

    // Run one instruction from its first FETCH cycle until the next one
    // starts (or the machine parks), counting cycles.
    task automatic applyStimulus(input logic [5:0] op, input int fd, input int md,
                                 input string nm, input int expCycles);
        int n;
        fetchDelay = fd; memDelay = md; opcode = op; n = 0;
        do begin
            @(posedge clock); #1;
            n++;
            if (n == 2) begin
                snapAlu = ALUOp; snapNe = BranchNe; snapCond = PCWriteCond; snapSrcB = ALUSrcB;
            end
            if (n == 3) begin snapRegDst = RegDst; snapRegWrite = RegWrite; end
        end while (!((cur == S_IF && mwait == 0) || cur == S_DEAD) && n < 60);
        checkOutput({nm, " cycles"}, n, expCycles);
    endtask

    initial begin
        #100000;
        errors++;
        $display("[TB] FAIL global timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int n;
        reset = 1'b1; opcode = 6'b0;
        repeat (2) @(posedge clock);
        #3;
        checkOutput("reset outputs", {11'b0, dutVec}, 32'h0);
        reset = 1'b0;
        #1 checkOutput("RST cycle MemRead", MemRead, 0);
        @(posedge clock); #1;
        checkOutput("first FETCH MemRead", MemRead, 1);

        applyStimulus(6'b000000, 0, 0, "add", 4);
        checkOutput("add ALUOp", snapAlu, 4'b0000);
        checkOutput("add RWB RegDst", snapRegDst, 1);
        checkOutput("add RWB RegWrite", snapRegWrite, 1);
        applyStimulus(6'b100011, 3, 3, "lw", 11);
        applyStimulus(6'b101011, 0, 1, "sw", 5);
        applyStimulus(6'b000100, 0, 0, "beq", 3);
        checkOutput("beq ALUOp", snapAlu, 4'b0100);
        checkOutput("beq BranchNe", snapNe, 0);
        checkOutput("beq PCWriteCond", snapCond, 1);
        applyStimulus(6'b000101, 0, 0, "bne", 3);
        checkOutput("bne ALUOp", snapAlu, 4'b0101);
        checkOutput("bne BranchNe", snapNe, 1);
        applyStimulus(6'b001101, 0, 0, "ori", 4);
        checkOutput("ori ALUOp", snapAlu, 4'b1101);
        checkOutput("ori ALUSrcB", snapSrcB, 2'b10);
        checkOutput("ori IWB RegDst", snapRegDst, 0);
        checkOutput("ori IWB RegWrite", snapRegWrite, 1);
        applyStimulus(6'b000010, 0, 0, "j", 3);
        applyStimulus(6'b001010, 1, 0, "slti", 5);
        checkOutput("slti ALUOp", snapAlu, 4'b0010);
        applyStimulus(6'b111111, 0, 0, "undefined", 2);
`ifdef MC_MAIN_CTRL_TRAP_EN
        checkOutput("illegal_instr", illegal_instr, 1);
`else
        checkOutput("illegal_instr", illegal_instr, 0);
`endif

        // Reset in the middle of a stalled load.
        reset = 1'b1;
        @(posedge clock); #3;
        reset = 1'b0;
        fetchDelay = 0; memDelay = 99; opcode = 6'b100011;
        n = 0;
        while (!(cur == S_LOAD && mwait == 2) && n < 30) begin
            @(posedge clock); #1; n++;
        end
        checkOutput("reached MEMRD", (n < 30) ? 1 : 0, 1);
        fetchDelay = 99;
        #2 reset = 1'b1;
        #1 checkOutput("mid-MEMRD reset outputs", {11'b0, dutVec}, 32'h0);
        @(posedge clock); #3;
        reset = 1'b0;
        #1 checkOutput("post-reset RST MemRead", MemRead, 0);
        @(posedge clock); #1;
        checkOutput("post-reset FETCH MemRead", MemRead, 1);

        // Watchdog: mem_ready never arrives in FETCH.
        n = 1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            if (MemRead) n++;
            else break;
        end
        checkOutput("watchdog FETCH cycles", n, 5);
        checkOutput("HALT outputs", {11'b0, dutVec}, 32'h2);

        reset = 1'b1;
        #1 checkOutput("bus_err cleared", bus_err, 0);
        @(posedge clock); #3;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
